seven_seg_scan_decoder: RTL and testbench

Sequential decoder that reads a time-multiplexed, active-low seven-segment display bus and recovers the hex value shown. It is the inverse of the lab's binary-to-seven-segment encoders. It sits on the display side of the datapath as a loopback/monitor: it samples segment pattern plus digit select, debounces each digit, and decodes it to a 4-bit nibble. When every digit has been captured it presents the assembled frame through a val/rdy handshake.

---
 rtl/seven_seg_scan_decoder.sv | 178 +++++++++++++++++
 tb/tb_seven_seg_scan_decoder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_decoder.sv
// seven_seg_scan_decoder
//
// Monitors a time-multiplexed, active-low seven-segment display bus and
// recovers the hex digits being shown. Each digit must be held stable for
// STABLE_CYCLES consecutive cycles before it is captured into its nibble
// slot. Once every slot has been captured the assembled frame is presented
// through a val/rdy handshake.
//
// Parameters
//   NDIGITS        number of multiplexed digits (1..8)
//   STABLE_CYCLES  consecutive identical samples needed to capture (2..255)
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   seg_in     segment pattern, bit0=a .. bit6=g, active low
//   digit_sel  one-hot digit select, bit i selects nibble i
//   out_val    assembled frame valid (registered)
//   out_rdy    consumer ready
//   out_value  decoded frame, nibble i from digit i
//   out_err    frame contains at least one unrecognised pattern
//   overrun    sticky, a capture was dropped while a frame was pending
//
// Optional feature (macro SEVEN_SEG_SCAN_DECODER_DP_EN):
//   dp_in      decimal point, active low; part of the stability comparison
//   out_dp     captured decimal points, active high, one bit per digit

module seven_seg_scan_decoder #(
    parameter int NDIGITS       = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [6:0]             seg_in,
    input  logic [NDIGITS-1:0]     digit_sel,
`ifdef SEVEN_SEG_SCAN_DECODER_DP_EN
    input  logic                   dp_in,
    output logic [NDIGITS-1:0]     out_dp,
`endif
    output logic                   out_val,
    input  logic                   out_rdy,
    output logic [4*NDIGITS-1:0]   out_value,
    output logic                   out_err,
    output logic                   overrun
);

`ifdef SEVEN_SEG_SCAN_DECODER_DP_EN
    localparam int SW = 8 + NDIGITS;
`else
    localparam int SW = 7 + NDIGITS;
`endif

    // Returns {valid, nibble}; unrecognised patterns decode to nibble 0.
    function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
        case (seg)
            7'b1000000: return {1'b1, 4'h0};
            7'b1111001: return {1'b1, 4'h1};
            7'b0100100: return {1'b1, 4'h2};
            7'b0110000: return {1'b1, 4'h3};
            7'b0011001: return {1'b1, 4'h4};
            7'b0010010: return {1'b1, 4'h5};
            7'b0000010: return {1'b1, 4'h6};
            7'b1111000: return {1'b1, 4'h7};
            7'b0000000: return {1'b1, 4'h8};
            7'b0010000: return {1'b1, 4'h9};
            7'b0001000: return {1'b1, 4'hA};
            7'b0000011: return {1'b1, 4'hB};
            7'b1000110: return {1'b1, 4'hC};
            7'b0100001: return {1'b1, 4'hD};
            7'b0000110: return {1'b1, 4'hE};
            7'b0001110: return {1'b1, 4'hF};
            default:    return 5'b0_0000;
        endcase
    endfunction

    logic [SW-1:0]      prev_reg;
    logic [7:0]         run_reg, run_next;
    logic [NDIGITS-1:0] mask_reg, mask_next;
    logic               err_reg, err_next;
    logic               val_reg, val_next;
    logic               overrun_reg, overrun_next;
    logic [3:0]         slot_reg [NDIGITS];

    logic [SW-1:0]      sample;
    logic               sel_ok;
    logic               capture;
    logic               accept;
    logic               write_en;
    logic [4:0]         glyph;

    always_comb begin
`ifdef SEVEN_SEG_SCAN_DECODER_DP_EN
        sample = {dp_in, seg_in, digit_sel};
`else
        sample = {seg_in, digit_sel};
`endif
        sel_ok = (digit_sel != '0) && ((digit_sel & (digit_sel - 1'b1)) == '0);
        glyph  = decode_glyph(seg_in);

        // Run length counts the current cycle; a fresh run starts at 1 and
        // saturates at STABLE_CYCLES so a long hold captures exactly once.
        run_next = 8'd0;
        if (sel_ok) begin
            if (sample != prev_reg)
                run_next = 8'd1;
            else if (run_reg < 8'(STABLE_CYCLES))
                run_next = run_reg + 8'd1;
            else
                run_next = run_reg;
        end

        capture  = sel_ok && (sample == prev_reg) && (run_reg == 8'(STABLE_CYCLES - 1));
        accept   = val_reg && out_rdy;
        // A pending frame that is not being accepted on this edge blocks capture.
        write_en = capture && !(val_reg && !out_rdy);

        // Accept clears the frame first so a same-edge capture lands in the
        // fresh frame.
        mask_next = accept ? '0 : mask_reg;
        err_next  = accept ? 1'b0 : err_reg;
        if (write_en) begin
            mask_next = mask_next | digit_sel;
            if (!glyph[4])
                err_next = 1'b1;
        end
        val_next     = &mask_next;
        overrun_next = overrun_reg | (capture && !write_en);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_reg    <= '0;
            run_reg     <= 8'd0;
            mask_reg    <= '0;
            err_reg     <= 1'b0;
            val_reg     <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            prev_reg    <= sample;
            run_reg     <= run_next;
            mask_reg    <= mask_next;
            err_reg     <= err_next;
            val_reg     <= val_next;
            overrun_reg <= overrun_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NDIGITS; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (rst)
                    slot_reg[gi] <= 4'h0;
                else if (write_en && digit_sel[gi])
                    slot_reg[gi] <= glyph[3:0];
            end
            assign out_value[4*gi +: 4] = slot_reg[gi];

`ifdef SEVEN_SEG_SCAN_DECODER_DP_EN
            logic dp_reg;
            always_ff @(posedge clk) begin
                if (rst)
                    dp_reg <= 1'b0;
                else if (write_en && digit_sel[gi])
                    dp_reg <= ~dp_in;
                else if (accept)
                    dp_reg <= 1'b0;
            end
            assign out_dp[gi] = dp_reg;
`endif
        end
    endgenerate

    assign out_val = val_reg;
    assign out_err = err_reg;
    assign overrun = overrun_reg;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// tb_seven_seg_scan_decoder
//
// Directed bench for seven_seg_scan_decoder (NDIGITS=4, STABLE_CYCLES=4).
// Expected frames are queued as each frame's stimulus is written and are
// popped and compared on the cycle the DUT hands the frame over
// (out_val && out_rdy). Inputs change #1 after the rising edge and outputs
// are inspected at that same point.

module tb_seven_seg_scan_decoder;

    localparam int ND = 4;
    localparam int SC = 4;

    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    localparam logic [6:0] BLANK = 7'b1111111;

    typedef struct {
        logic [4*ND-1:0] value;
        logic            err;
    } frame_t;

    logic              clk;
    logic              rst;
    logic [6:0]        seg_in;
    logic [ND-1:0]     digit_sel;
    logic              out_val;
    logic              out_rdy;
    logic [4*ND-1:0]   out_value;
    logic              out_err;
    logic              overrun;
`ifdef SEVEN_SEG_SCAN_DECODER_DP_EN
    logic              dp_in;
    logic [ND-1:0]     out_dp;
`endif

    frame_t exp_q[$];
    int     tests_run;
    int     tests_failed;
    int     val_cycles;

    seven_seg_scan_decoder #(
        .NDIGITS       (ND),
        .STABLE_CYCLES (SC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_in    (seg_in),
        .digit_sel (digit_sel),
`ifdef SEVEN_SEG_SCAN_DECODER_DP_EN
        .dp_in     (dp_in),
        .out_dp    (out_dp),
`endif
        .out_val   (out_val),
        .out_rdy   (out_rdy),
        .out_value (out_value),
        .out_err   (out_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock cycle. If a handshake is about to happen on the coming edge,
    // the frame being handed over is checked against the scoreboard.
    task automatic tick();
        frame_t f;
        if (out_val === 1'b1) val_cycles++;
        if (out_val === 1'b1 && out_rdy === 1'b1) begin
            tests_run++;
            assert (exp_q.size() != 0) else begin
                tests_failed++;
                $error("FAIL unexpected_frame observed=%0h expected=none", out_value);
            end
            if (exp_q.size() != 0) begin
                f = exp_q.pop_front();
                check("frame_value", 64'(out_value), 64'(f.value));
                check("frame_err", 64'(out_err), 64'(f.err));
                $display("[TB] frame handed over value=%h err=%0d", out_value, out_err);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic show(input int d, input logic [6:0] seg, input int n);
        digit_sel = ND'(1) << d;
        seg_in    = seg;
        repeat (n) tick();
    endtask

    task automatic idle(input int n);
        digit_sel = '0;
        seg_in    = BLANK;
        repeat (n) tick();
    endtask

    task automatic push(input logic [4*ND-1:0] v, input logic e);
        frame_t f;
        f.value = v;
        f.err   = e;
        exp_q.push_back(f);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        val_cycles   = 0;
        rst       = 1'b1;
        seg_in    = BLANK;
        digit_sel = '0;
        out_rdy   = 1'b0;
`ifdef SEVEN_SEG_SCAN_DECODER_DP_EN
        dp_in     = 1'b1;
`endif

        // Reset then idle
        repeat (2) tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            check("idle_outputs", {out_val, out_err, overrun, out_value}, 64'd0);
            tick();
        end

        // Full frame 3,0,0,2 with consumer ready
        out_rdy    = 1'b1;
        val_cycles = 0;
        push(16'h3002, 1'b0);
        show(0, GLYPH[2], SC);
        show(1, GLYPH[0], SC);
        show(2, GLYPH[0], SC);
        check("frame1_not_yet", 64'(out_val), 64'd0);
        show(3, GLYPH[3], SC);
        check("frame1_val", 64'(out_val), 64'd1);
        idle(3);
        check("frame1_val_cycles", 64'(val_cycles), 64'd1);
        check("frame1_popped", 64'(exp_q.size()), 64'd0);

        // Glitch rejection: 3-cycle run of 8 on digit 0 never captures
        push(16'h6541, 1'b0);
        show(1, GLYPH[4], SC);
        show(2, GLYPH[5], SC);
        show(3, GLYPH[6], SC);
        show(0, GLYPH[8], SC - 1);
        check("glitch_no_capture", 64'(out_val), 64'd0);
        show(0, GLYPH[1], SC);
        check("glitch_frame_val", 64'(out_val), 64'd1);
        idle(2);

        // Invalid pattern on digit 2
        push(16'hA0C5, 1'b1);
        show(0, GLYPH[5], SC);
        show(1, GLYPH[12], SC);
        show(2, BLANK, SC);
        show(3, GLYPH[10], SC);
        check("invalid_val", 64'(out_val), 64'd1);
        check("invalid_err", 64'(out_err), 64'd1);
        idle(2);

        // Backpressure and overrun
        out_rdy = 1'b0;
        push(16'h1234, 1'b0);
        show(0, GLYPH[4], SC);
        show(1, GLYPH[3], SC);
        show(2, GLYPH[2], SC);
        show(3, GLYPH[1], SC);
        check("bp_val", 64'(out_val), 64'd1);
        check("bp_overrun_clear", 64'(overrun), 64'd0);
        show(1, GLYPH[9], SC);
        check("bp_val_held", 64'(out_val), 64'd1);
        check("bp_value_held", 64'(out_value), 64'h1234);
        check("bp_overrun_set", 64'(overrun), 64'd1);
        out_rdy = 1'b1;
        idle(1);
        check("bp_val_dropped", 64'(out_val), 64'd0);

        // Accept and capture on the same edge
        out_rdy = 1'b0;
        push(16'h5678, 1'b0);
        show(0, GLYPH[8], SC);
        show(1, GLYPH[7], SC);
        show(2, GLYPH[6], SC);
        show(3, GLYPH[5], SC);
        check("sim_pending", 64'(out_val), 64'd1);
        show(0, GLYPH[15], SC - 1);
        out_rdy = 1'b1;
        tick();
        check("sim_val_after", 64'(out_val), 64'd0);
        check("sim_nibble0", 64'(out_value[3:0]), 64'hF);
        push(16'h321F, 1'b0);
        show(1, GLYPH[1], SC);
        show(2, GLYPH[2], SC);
        check("sim_mask_partial", 64'(out_val), 64'd0);
        show(3, GLYPH[3], SC);
        check("sim_new_frame_val", 64'(out_val), 64'd1);
        idle(2);

        // Reset mid-frame discards captured digits and the sticky overrun
        show(0, GLYPH[9], SC);
        show(1, GLYPH[9], SC);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("rst_overrun", 64'(overrun), 64'd0);
        push(16'h87CD, 1'b0);
        show(2, GLYPH[7], SC);
        show(3, GLYPH[8], SC);
        check("rst_mask_cleared", 64'(out_val), 64'd0);
        show(0, GLYPH[13], SC);
        show(1, GLYPH[12], SC);
        check("rst_refill_val", 64'(out_val), 64'd1);
        idle(2);

        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
